// File: rtl/draw_pkg.sv
// Shared definitions for the hangman drawing engines and the plot-port arbiter.
package draw_pkg;

    localparam int REQ_CLEAR = 0;
    localparam int REQ_GRAPH = 1;
    localparam int REQ_DASH  = 2;
    localparam int REQ_FILL  = 3;
    localparam int REQ_PARTS = 4;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Clear (index 0) never moves the pointer; other engines hand off to the next one, wrapping past 0.
    function automatic logic [2:0] next_rr(input logic [2:0] g, input logic [2:0] rr, input int nreq);
        if (g == 3'd0)
            return rr;
        else if (int'(g) == nreq - 1)
            return 3'd1;
        else
            return g + 3'd1;
    endfunction

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker over requesters 1..NREQ-1, starting the search at rr.
module rr_pick #(
    parameter int NREQ = 5
) (
    input  logic [NREQ-1:1] req_hi,
    input  logic [2:0]      rr,
    output logic [NREQ-1:0] winner
);

    logic       found;
    logic [2:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ - 1; k++) begin
            idx = 3'(((int'(rr) + NREQ - 2 + k) % (NREQ - 1)) + 1);
            if (!found && req_hi[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the VGA plot port between the drawing engines: one grant at a time,
// registered pixel forwarding, done pulse on the last pixel, and a stall watchdog.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int NREQ    = 5,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         pix_valid,
    input  logic [NREQ-1:0]         pix_last,
    input  logic [NREQ*X_W-1:0]     pix_x,
    input  logic [NREQ*Y_W-1:0]     pix_y,
    input  logic [NREQ*COLOR_W-1:0] pix_color,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [X_W-1:0]          x,
    output logic [Y_W-1:0]          y,
    output logic [COLOR_W-1:0]      colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    err,
    output logic [2:0]              err_id
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_t         state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] colour_q, colour_d;
    logic               plot_q, plot_d;
    logic               err_q, err_d;
    logic [2:0]         err_id_q, err_id_d;
    logic [2:0]         rr_q, rr_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic [2:0]         gidx;
    logic [NREQ-1:0]    rr_winner;
    logic               accept;

    rr_pick #(
        .NREQ   (NREQ)
    ) u_rr_pick (
        .req_hi (req[NREQ-1:1]),
        .rr     (rr_q),
        .winner (rr_winner)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i])
                gidx = 3'(i);
        end
    end

    assign accept = (state_q == ST_GRANT) && pix_valid[gidx];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        err_d      = err_q;
        err_id_d   = err_id_q;
        rr_d       = rr_q;
        idle_cnt_d = idle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d    = req[0] ? {{(NREQ-1){1'b0}}, 1'b1} : rr_winner;
                    state_d    = ST_GRANT;
                    idle_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    x_d        = pix_x[gidx*X_W +: X_W];
                    y_d        = pix_y[gidx*Y_W +: Y_W];
                    colour_d   = pix_color[gidx*COLOR_W +: COLOR_W];
                    plot_d     = 1'b1;
                    idle_cnt_d = '0;
                    if (pix_last[gidx]) begin
                        done_d  = grant_q;
                        grant_d = '0;
                        state_d = ST_IDLE;
                        rr_d    = next_rr(gidx, rr_q, NREQ);
                    end
                end else if (idle_cnt_q == TIMEOUT_CNT) begin
                    // Stalled engine loses the port without a done so it can tell it was cut off.
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                    err_d    = 1'b1;
                    err_id_d = gidx;
                    rr_d     = next_rr(gidx, rr_q, NREQ);
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            err_q      <= 1'b0;
            err_id_q   <= '0;
            rr_q       <= 3'd1;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            err_q      <= err_d;
            err_id_q   <= err_id_d;
            rr_q       <= rr_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = (state_q == ST_GRANT);
    assign err    = err_q;
    assign err_id = err_id_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed self-checking bench for draw_arbiter with a short watchdog (TIMEOUT = 4).
module tb_draw_arbiter;

    localparam int NREQ = 5;
    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int C_W  = 3;
    localparam int TO   = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   pix_valid;
    logic [NREQ-1:0]   pix_last;
    logic [NREQ*X_W-1:0] pix_x;
    logic [NREQ*Y_W-1:0] pix_y;
    logic [NREQ*C_W-1:0] pix_color;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [C_W-1:0]    colour;
    logic              plot;
    logic              busy;
    logic              err;
    logic [2:0]        err_id;

    int tests_run    = 0;
    int tests_failed = 0;

    draw_arbiter #(
        .NREQ     (NREQ),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOR_W  (C_W),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .grant     (grant),
        .done      (done),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .err       (err),
        .err_id    (err_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic v, input logic l,
                           input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        pix_valid[i]         = v;
        pix_last[i]          = l;
        pix_x[i*X_W +: X_W]  = px;
        pix_y[i*Y_W +: Y_W]  = py;
        pix_color[i*C_W +: C_W] = pc;
    endtask

    task automatic test_reset();
        resetn    = 1'b1;
        req       = '0;
        pix_valid = '0;
        pix_last  = '0;
        pix_x     = '0;
        pix_y     = '0;
        pix_color = '0;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        tests_run++;
        if ({grant, done, plot, busy, err, err_id} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got grant=%b done=%b plot=%b busy=%b err=%b err_id=%0d want all 0",
                     grant, done, plot, busy, err, err_id);
        end
        tests_run++;
        if ({x, y, colour} !== '0) begin
            tests_failed++;
            $display("FAIL reset_pix: got x=%0d y=%0d colour=%b want 0", x, y, colour);
        end
    endtask

    task automatic test_clear_priority();
        req = 5'b10011;
        tick();
        tests_run++;
        if (grant !== 5'b00001) begin
            tests_failed++;
            $display("FAIL clear_first: got %b want 00001", grant);
        end
        req = 5'b10010;
        set_pix(0, 1'b1, 1'b1, 8'd5, 7'd6, 3'b001);
        tick();
        tests_run++;
        if ({done, grant, plot, x, y, colour} !== {5'b00001, 5'b00000, 1'b1, 8'd5, 7'd6, 3'b001}) begin
            tests_failed++;
            $display("FAIL clear_done: got done=%b grant=%b plot=%b x=%0d y=%0d c=%b want done=00001 grant=0 plot=1 (5,6) c=001",
                     done, grant, plot, x, y, colour);
        end
        set_pix(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
        tests_run++;
        if (grant !== 5'b00010) begin
            tests_failed++;
            $display("FAIL clear_then_graph: got %b want 00010", grant);
        end
        req = 5'b10000;
        set_pix(1, 1'b1, 1'b1, 8'd1, 7'd1, 3'b010);
        tick();
        tests_run++;
        if ({done, grant} !== {5'b00010, 5'b00000}) begin
            tests_failed++;
            $display("FAIL graph_done: got done=%b grant=%b want 00010/00000", done, grant);
        end
        set_pix(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
        tests_run++;
        if (grant !== 5'b10000) begin
            tests_failed++;
            $display("FAIL rr_to_parts: got %b want 10000", grant);
        end
        req = 5'b00000;
        set_pix(4, 1'b1, 1'b1, 8'd4, 7'd4, 3'b100);
        tick();
        tests_run++;
        if (done !== 5'b10000) begin
            tests_failed++;
            $display("FAIL parts_done: got %b want 10000", done);
        end
        set_pix(4, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
        tests_run++;
        if ({grant, plot, done} !== '0) begin
            tests_failed++;
            $display("FAIL clear_idle: got grant=%b plot=%b done=%b want 0", grant, plot, done);
        end
    endtask

    task automatic test_single_job();
        logic [7:0] xs [3];
        xs[0] = 8'd10;
        xs[1] = 8'd11;
        xs[2] = 8'd12;
        req = 5'b00100;
        tick();
        tests_run++;
        if ({grant, busy} !== {5'b00100, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_grant: got grant=%b busy=%b want 00100/1", grant, busy);
        end
        req = '0;
        for (int k = 0; k < 3; k++) begin
            set_pix(2, 1'b1, (k == 2), xs[k], 7'd50, 3'b111);
            tick();
            tests_run++;
            if ({plot, x, y, colour} !== {1'b1, xs[k], 7'd50, 3'b111}) begin
                tests_failed++;
                $display("FAIL single_pix%0d: got plot=%b (%0d,%0d) c=%b want plot=1 (%0d,50) c=111",
                         k, plot, x, y, colour, xs[k]);
            end
            tests_run++;
            if ({done, grant} !== ((k == 2) ? {5'b00100, 5'b00000} : {5'b00000, 5'b00100})) begin
                tests_failed++;
                $display("FAIL single_done%0d: got done=%b grant=%b", k, done, grant);
            end
        end
        set_pix(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
        tests_run++;
        if ({plot, done, busy} !== '0) begin
            tests_failed++;
            $display("FAIL single_after: got plot=%b done=%b busy=%b want 0", plot, done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g;
        logic [4:0] exp_d;
        logic [7:0] exp_x;
        // rr is 3 here: engine 3 goes first, then 1, 3, 1.
        req = 5'b01010;
        set_pix(1, 1'b1, 1'b1, 8'd21, 7'd1, 3'b001);
        set_pix(3, 1'b1, 1'b1, 8'd23, 7'd3, 3'b011);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = '0;
            exp_d = '0;
            exp_x = 8'd0;
            if (k % 2 == 0)
                exp_g = (k % 4 == 0) ? 5'b01000 : 5'b00010;
            else begin
                exp_d = (k % 4 == 1) ? 5'b01000 : 5'b00010;
                exp_x = (k % 4 == 1) ? 8'd23 : 8'd21;
            end
            tests_run++;
            if ({grant, done} !== {exp_g, exp_d}) begin
                tests_failed++;
                $display("FAIL rr_cycle%0d: got grant=%b done=%b want %b/%b", k, grant, done, exp_g, exp_d);
            end
            if (k % 2 == 1) begin
                tests_run++;
                if ({plot, x} !== {1'b1, exp_x}) begin
                    tests_failed++;
                    $display("FAIL rr_plot%0d: got plot=%b x=%0d want 1/%0d", k, plot, x, exp_x);
                end
            end
        end
        req = '0;
        set_pix(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        set_pix(3, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
    endtask

    task automatic test_timeout();
        // rr is 2 here, so a lone request from engine 3 is granted.
        req = 5'b01000;
        tick();
        for (int k = 0; k <= TO; k++) begin
            tests_run++;
            if ({grant, done, err} !== {5'b01000, 5'b00000, 1'b0}) begin
                tests_failed++;
                $display("FAIL to_hold%0d: got grant=%b done=%b err=%b want 01000/0/0", k, grant, done, err);
            end
            req = 5'b01010;
            tick();
        end
        tests_run++;
        if ({grant, done, busy, err, err_id} !== {5'b00000, 5'b00000, 1'b0, 1'b1, 3'd3}) begin
            tests_failed++;
            $display("FAIL to_revoke: got grant=%b done=%b busy=%b err=%b err_id=%0d want 0/0/0/1/3",
                     grant, done, busy, err, err_id);
        end
        req = 5'b00010;
        tick();
        tests_run++;
        if (grant !== 5'b00010) begin
            tests_failed++;
            $display("FAIL to_next: got %b want 00010", grant);
        end
        req = '0;
        set_pix(1, 1'b1, 1'b1, 8'd2, 7'd2, 3'b010);
        tick();
        tests_run++;
        if ({done, err} !== {5'b00010, 1'b1}) begin
            tests_failed++;
            $display("FAIL to_sticky: got done=%b err=%b want 00010/1", done, err);
        end
        set_pix(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
    endtask

    task automatic test_noise();
        req = 5'b00010;
        set_pix(4, 1'b1, 1'b1, 8'd99, 7'd99, 3'b100);
        tick();
        tests_run++;
        if ({grant, plot} !== {5'b00010, 1'b0}) begin
            tests_failed++;
            $display("FAIL noise_grant: got grant=%b plot=%b want 00010/0", grant, plot);
        end
        req = '0;
        set_pix(1, 1'b1, 1'b0, 8'd30, 7'd40, 3'b010);
        tick();
        tests_run++;
        if ({plot, x, y, done} !== {1'b1, 8'd30, 7'd40, 5'b00000}) begin
            tests_failed++;
            $display("FAIL noise_pix0: got plot=%b (%0d,%0d) done=%b want 1 (30,40) 0", plot, x, y, done);
        end
        set_pix(1, 1'b1, 1'b1, 8'd31, 7'd40, 3'b010);
        tick();
        tests_run++;
        if ({plot, x, y, colour, done} !== {1'b1, 8'd31, 7'd40, 3'b010, 5'b00010}) begin
            tests_failed++;
            $display("FAIL noise_pix1: got plot=%b (%0d,%0d) c=%b done=%b want 1 (31,40) 010 00010",
                     plot, x, y, colour, done);
        end
        set_pix(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
        tests_run++;
        if ({plot, grant, done} !== '0) begin
            tests_failed++;
            $display("FAIL noise_idle: got plot=%b grant=%b done=%b want 0", plot, grant, done);
        end
        set_pix(4, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
    endtask

    task automatic test_reset_mid_job();
        // rr is 2 here; after reset it must be back at 1.
        req = 5'b00100;
        tick();
        req = '0;
        set_pix(2, 1'b1, 1'b0, 8'd7, 7'd8, 3'b011);
        tick();
        tests_run++;
        if ({plot, x} !== {1'b1, 8'd7}) begin
            tests_failed++;
            $display("FAIL mid_pix: got plot=%b x=%0d want 1/7", plot, x);
        end
        resetn = 1'b1;
        #1;
        tests_run++;
        if ({grant, done, plot, busy, err, err_id, x, y, colour} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got grant=%b done=%b plot=%b busy=%b err=%b x=%0d want all 0",
                     grant, done, plot, busy, err, x);
        end
        set_pix(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000);
        tick();
        resetn = 1'b0;
        req = 5'b00110;
        tick();
        tests_run++;
        if ({grant, done} !== {5'b00010, 5'b00000}) begin
            tests_failed++;
            $display("FAIL mid_rr: got grant=%b done=%b want 00010/0", grant, done);
        end
        req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        test_reset();
        test_clear_priority();
        test_single_job();
        test_round_robin();
        test_timeout();
        test_noise();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
